// File: rtl/msix_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : msix_arbiter_if
//  Purpose  : Request handshake between the MSI-X arbiter (master) and the
//             MSI-X write stage (slave): fire/index out, ready/complete back.
//  Revision : 1.0  initial release
// ============================================================================
interface msix_arbiter_if #(
  parameter int IDX_W = 3
);
  logic             req_fire;
  logic [IDX_W-1:0] req_index;
  logic             req_ready;
  logic             req_complete;

  // Arbiter side: issues requests, observes stage status.
  modport master (
    output req_fire,
    output req_index,
    input  req_ready,
    input  req_complete
  );

  // MSI-X stage side: consumes requests, reports status.
  modport slave (
    input  req_fire,
    input  req_index,
    output req_ready,
    output req_complete
  );
endinterface
`default_nettype wire

// File: rtl/msix_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : msix_arbiter
//  Purpose  : Collects per-vector interrupt requests into the Pending Bit
//             Array, applies vector/function masking and picks one eligible
//             vector round-robin for the MSI-X write stage.
//  Revision : 1.0  initial release
// ============================================================================
module msix_arbiter #(
  parameter int NUM_VECTORS = 8,
  parameter int IDX_W       = $clog2(NUM_VECTORS)
) (
  input  wire logic                   clk_pcie,
  input  wire logic                   rst,
  input  wire logic [NUM_VECTORS-1:0] irq_req,
  input  wire logic [NUM_VECTORS-1:0] vector_mask,
  input  wire logic                   function_mask,
  input  wire logic                   msix_enable,
  msix_arbiter_if.master              req_if,
  output logic      [NUM_VECTORS-1:0] pba,
  output logic                        busy,
  output logic      [31:0]            msg_count
);

  // One extra bit so the wrap-around sum of pointer and offset cannot overflow.
  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    req_fire_q, req_fire_d;
  logic [IDX_W-1:0]        req_index_q, req_index_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_VECTORS-1:0]  pba_q, pba_d;
  logic [31:0]             msg_count_q, msg_count_d;

  logic [NUM_VECTORS-1:0]  eligible;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;
  logic [CW-1:0]           cand;
  logic                    complete_evt;

  // A completion is only meaningful while a request is outstanding.
  assign complete_evt = (state_q == ST_ISSUE) && req_if.req_complete;

  // Pending vectors that are neither masked individually nor globally.
  assign eligible = pba_q & ~vector_mask & {NUM_VECTORS{~function_mask & msix_enable}};

  // Round-robin search: first eligible vector starting at rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_VECTORS; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_VECTORS)) begin
        cand = cand - CW'(NUM_VECTORS);
      end
      if (!grant_valid && eligible[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // PBA update: completion clears the issued bit, new requests set (set wins).
  always_comb begin
    pba_d = pba_q;
    if (!msix_enable) begin
      pba_d = '0;
    end else begin
      if (complete_evt) begin
        pba_d[req_index_q] = 1'b0;
      end
      pba_d = pba_d | irq_req;
    end
  end

  // Handshake FSM: grant in IDLE, hold until complete, wait for stage release.
  always_comb begin
    state_d     = state_q;
    req_fire_d  = req_fire_q;
    req_index_d = req_index_q;
    rr_ptr_d    = rr_ptr_q;
    msg_count_d = msg_count_q;
    case (state_q)
      ST_IDLE: begin
        req_fire_d = 1'b0;
        if (req_if.req_ready && grant_valid) begin
          req_index_d = grant_idx;
          req_fire_d  = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        req_fire_d = 1'b1;
        if (req_if.req_complete) begin
          req_fire_d  = 1'b0;
          msg_count_d = msg_count_q + 32'd1;
          rr_ptr_d    = (req_index_q == IDX_W'(NUM_VECTORS - 1)) ? '0
                                                                 : req_index_q + IDX_W'(1);
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        req_fire_d = 1'b0;
        if (!req_if.req_complete && req_if.req_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_fire_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset takes effect without a clock edge.
  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_fire_q  <= 1'b0;
      req_index_q <= '0;
      rr_ptr_q    <= '0;
      pba_q       <= '0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      req_fire_q  <= req_fire_d;
      req_index_q <= req_index_d;
      rr_ptr_q    <= rr_ptr_d;
      pba_q       <= pba_d;
      msg_count_q <= msg_count_d;
    end
  end

  assign req_if.req_fire  = req_fire_q;
  assign req_if.req_index = req_index_q;
  assign pba              = pba_q;
  assign busy             = (state_q != ST_IDLE);
  assign msg_count        = msg_count_q;

endmodule
`default_nettype wire

// File: tb/tb_msix_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msix_arbiter
//  Purpose  : Directed scoreboard bench for msix_arbiter with a simple
//             MSI-X stage model answering each request after a fixed delay.
//  Revision : 1.0  initial release
// ============================================================================
module tb_msix_arbiter;

  localparam int NV        = 8;
  localparam int IW        = 3;
  localparam int STAGE_DLY = 5;

  logic           clk_pcie = 1'b0;
  logic           rst;
  logic [NV-1:0]  irq_req;
  logic [NV-1:0]  vector_mask;
  logic           function_mask;
  logic           msix_enable;
  logic [NV-1:0]  pba;
  logic           busy;
  logic [31:0]    msg_count;

  msix_arbiter_if #(.IDX_W(IW)) bus ();

  msix_arbiter #(.NUM_VECTORS(NV), .IDX_W(IW)) dut (
    .clk_pcie      (clk_pcie),
    .rst           (rst),
    .irq_req       (irq_req),
    .vector_mask   (vector_mask),
    .function_mask (function_mask),
    .msix_enable   (msix_enable),
    .req_if        (bus),
    .pba           (pba),
    .busy          (busy),
    .msg_count     (msg_count)
  );

  always #5 clk_pcie = ~clk_pcie;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MSI-X stage model: takes a request, answers complete STAGE_DLY cycles later.
  int st_cnt;
  bit st_busy;
  always @(negedge clk_pcie) begin
    if (rst) begin
      st_busy          = 1'b0;
      st_cnt           = 0;
      bus.req_complete = 1'b0;
      bus.req_ready    = 1'b1;
    end else begin
      bus.req_complete = 1'b0;
      if (st_busy) begin
        st_cnt++;
        if (st_cnt == STAGE_DLY) begin
          bus.req_complete = 1'b1;
          bus.req_ready    = 1'b1;
          st_busy          = 1'b0;
        end
      end else if (bus.req_fire) begin
        st_busy       = 1'b1;
        st_cnt        = 0;
        bus.req_ready = 1'b0;
      end
    end
  end

  // Monitor: each new grant is matched against the scoreboard; index must
  // stay put for the whole transaction.
  logic [IW-1:0] held_idx;
  bit            prev_fire;
  bit            prev_busy;
  int            exp_idx;
  always @(negedge clk_pcie) begin
    if (rst) begin
      prev_fire = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.req_fire && !prev_fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fire: got index %0d expected no grant", bus.req_index);
        end else begin
          exp_idx = exp_q.pop_front();
          chk("grant_index", 32'(bus.req_index), 32'(exp_idx));
        end
        held_idx = bus.req_index;
      end else if (prev_busy && busy) begin
        chk("index_stable", 32'(bus.req_index), 32'(held_idx));
      end
      prev_fire = bus.req_fire;
      prev_busy = busy;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_pcie);
      #1;
    end
  endtask

  task automatic pulse(input logic [NV-1:0] v);
    irq_req = v;
    tick();
    irq_req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_fire(input string name);
    int n = 0;
    while (!bus.req_fire && n < 50) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.req_fire), 32'd1);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_unmask_fire(input string name);
    int n = 0;
    while (!bus.req_fire && n < 2) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.req_fire), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    irq_req       = '0;
    vector_mask   = '0;
    function_mask = 1'b0;
    msix_enable   = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_fire",   32'(bus.req_fire),  32'd0);
    chk("rst_index",  32'(bus.req_index), 32'd0);
    chk("rst_pba",    32'(pba),           32'd0);
    chk("rst_busy",   32'(busy),          32'd0);
    chk("rst_count",  msg_count,          32'd0);
    chk("rst_rr",     32'(dut.rr_ptr_q),  32'd0);

    // Single request on vector 2, two-cycle latency
    exp_q.push_back(2);
    pulse(8'h04);
    chk("single_n1_fire", 32'(bus.req_fire), 32'd0);
    chk("single_n1_pba",  32'(pba),          32'h04);
    tick();
    chk("single_n2_fire", 32'(bus.req_fire), 32'd1);
    wait_quiet("single_done");
    chk("single_pba",   32'(pba),          32'd0);
    chk("single_count", msg_count,         32'd1);
    chk("single_rr",    32'(dut.rr_ptr_q), 32'd3);

    // Round-robin from pointer 0, then wrap past the end
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(4);
    pulse(8'h13);
    wait_quiet("rr1_done");
    chk("rr1_count", msg_count,         32'd3);
    chk("rr1_ptr",   32'(dut.rr_ptr_q), 32'd5);
    exp_q.push_back(0);
    exp_q.push_back(1);
    pulse(8'h03);
    wait_quiet("rr2_done");
    chk("rr2_count", msg_count,         32'd5);
    chk("rr2_ptr",   32'(dut.rr_ptr_q), 32'd2);

    // Per-vector mask holds the request pending
    vector_mask = 8'h08;
    pulse(8'h08);
    tick(20);
    chk("vmask_pba",  32'(pba),          32'h08);
    chk("vmask_fire", 32'(bus.req_fire), 32'd0);
    exp_q.push_back(3);
    vector_mask = 8'h00;
    wait_unmask_fire("vmask_release_fire");
    wait_quiet("vmask_done");
    chk("vmask_count", msg_count, 32'd6);

    // Function mask holds the request pending
    function_mask = 1'b1;
    pulse(8'h08);
    tick(20);
    chk("fmask_pba",  32'(pba),          32'h08);
    chk("fmask_fire", 32'(bus.req_fire), 32'd0);
    exp_q.push_back(3);
    function_mask = 1'b0;
    wait_unmask_fire("fmask_release_fire");
    wait_quiet("fmask_done");
    chk("fmask_count", msg_count,         32'd7);
    chk("fmask_rr",    32'(dut.rr_ptr_q), 32'd4);

    // Re-request of vector 5 in the completion cycle: set wins
    do_reset();
    exp_q.push_back(5);
    exp_q.push_back(5);
    pulse(8'h20);
    n = 0;
    while (!bus.req_complete && n < 50) begin
      tick();
      n++;
    end
    chk("rereq_complete_seen", 32'(bus.req_complete), 32'd1);
    irq_req = 8'h20;
    tick();
    irq_req = '0;
    chk("rereq_pba5",  32'(pba[5]),       32'd1);
    chk("rereq_fire0", 32'(bus.req_fire), 32'd0);
    chk("rereq_cnt1",  msg_count,         32'd1);
    wait_quiet("rereq_done");
    chk("rereq_count", msg_count, 32'd2);
    chk("rereq_pba",   32'(pba),  32'd0);

    // Disable clears the PBA and drops requests
    function_mask = 1'b1;
    pulse(8'hFF);
    chk("dis_pba_full", 32'(pba), 32'hFF);
    msix_enable = 1'b0;
    tick();
    chk("dis_pba_clr", 32'(pba), 32'd0);
    pulse(8'hFF);
    chk("dis_pba_drop", 32'(pba), 32'd0);
    tick(5);
    chk("dis_fire", 32'(bus.req_fire), 32'd0);
    chk("dis_busy", 32'(busy),         32'd0);
    msix_enable   = 1'b1;
    function_mask = 1'b0;
    tick();
    chk("dis_pba_after", 32'(pba), 32'd0);

    // Disable mid-ISSUE: transaction still completes
    exp_q.push_back(6);
    pulse(8'h40);
    wait_fire("dis_mid_fire");
    msix_enable = 1'b0;
    wait_quiet("dis_mid_done");
    chk("dis_mid_count", msg_count, 32'd3);
    chk("dis_mid_pba",   32'(pba),  32'd0);
    msix_enable = 1'b1;
    tick();

    // Asynchronous reset while a request is outstanding
    exp_q.push_back(1);
    pulse(8'h02);
    wait_fire("arst_fire");
    rst = 1'b1;
    #1;
    chk("arst_fire0", 32'(bus.req_fire),  32'd0);
    chk("arst_pba",   32'(pba),           32'd0);
    chk("arst_count", msg_count,          32'd0);
    chk("arst_busy",  32'(busy),          32'd0);
    chk("arst_index", 32'(bus.req_index), 32'd0);
    tick(2);
    rst = 1'b0;
    tick();
    exp_q.push_back(7);
    pulse(8'h80);
    wait_quiet("arst_after_done");
    chk("arst_after_count", msg_count,         32'd1);
    chk("arst_after_rr",    32'(dut.rr_ptr_q), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msix_arbiter.md
# msix_arbiter

Upstream feeder for the MSI-X write stage. Collects per-vector interrupt requests from device logic and keeps them in a Pending Bit Array (PBA). Applies per-vector and function masking, picks one eligible vector round-robin, and drives the fire/index/ready/complete request handshake of the MSI-X stage. The MSI-X stage then turns that request into a posted memory write using the MSI-X table.

## Interface
Parameters:
- NUM_VECTORS, 8: number of MSI-X vectors; legal range 2..32.
- IDX_W, $clog2(NUM_VECTORS): width of the vector index.

Ports:
- clk_pcie  in  1  sole clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- irq_req  in  NUM_VECTORS  one-cycle request pulse per vector; a level is counted once per cycle.
- vector_mask  in  NUM_VECTORS  per-vector mask, from table Vector Control bit 0.
- function_mask  in  1  MSI-X Function Mask; masks all vectors.
- msix_enable  in  1  MSI-X Enable from the capability.
- req_fire  out  1  request to the MSI-X stage (maps to IfMsiXRequest.fire).
- req_index  out  IDX_W  vector being issued (maps to interrupter_index).
- req_ready  in  1  MSI-X stage idle (IfMsiXRequest.ready).
- req_complete  in  1  MSI-X stage finished its write (IfMsiXRequest.complete).
- pba  out  NUM_VECTORS  Pending Bit Array, readable via BAR.
- busy  out  1  transaction in flight (state != IDLE).
- msg_count  out  32  number of messages issued; wraps modulo 2^32.

## Operation
- PBA per vector, updated each cycle:
  - set on irq_req[i] while msix_enable = 1;
  - cleared when vector i completes (see ISSUE);
  - set and clear in the same cycle: set wins, so the bit stays 1;
  - msix_enable = 0 clears the whole PBA and drops incoming requests.
- Eligibility: eligible[i] = pba[i] & ~vector_mask[i] & ~function_mask & msix_enable. Masked vectors stay pending and become eligible once unmasked.
- Round-robin pointer rr_ptr (IDX_W bits, reset 0):
  - search order is rr_ptr, rr_ptr+1, ... wrapping modulo NUM_VECTORS;
  - after a completion, rr_ptr = issued index + 1, wrapping to 0 after NUM_VECTORS-1.
- State machine:
  - IDLE: if req_ready and any vector is eligible, latch the first eligible index into req_index, set req_fire = 1, go to ISSUE.
  - ISSUE: hold req_fire = 1 and req_index stable. On req_complete = 1: clear pba[req_index] (set-wins rule applies), advance rr_ptr, increment msg_count, drive req_fire = 0, go to RELEASE.
  - RELEASE: req_fire = 0, req_index held. When req_complete = 0 and req_ready = 1, go to IDLE.
- req_index must stay constant from the cycle fire rises until RELEASE exits, because the MSI-X stage re-reads the index during its data phase.
- Masking, msix_enable = 0 or function_mask asserted during ISSUE/RELEASE never aborts a transaction; it runs to completion.
  - If msix_enable drops mid-flight, the PBA is still cleared, so the later completion-clear has no effect.
- Reset (any time, including mid-transaction):
  - req_fire = 0, req_index = 0, pba = 0, busy = 0, msg_count = 0, rr_ptr = 0, state = IDLE.
  - The downstream stage is reset by the same rst.

## Timing
- irq_req pulse in cycle N → pba bit visible in cycle N+1 → req_fire high in cycle N+2, provided the vector is eligible and req_ready = 1. Minimum latency is 2 cycles.
- req_fire and req_index are registered outputs; no combinational path from inputs to them.
- req_complete high in cycle M → req_fire low, pba clear and msg_count+1 in cycle M+1.
- IDLE re-entry happens the cycle after req_complete = 0 and req_ready = 1 are both seen in RELEASE.
- Next grant is earliest 1 cycle after IDLE re-entry.
- One transaction at a time; no pipelining across vectors.

## Test plan
- Single request: irq_req = 8'h04 for one cycle, stage model asserts complete 5 cycles after fire → req_fire rises 2 cycles after the pulse with req_index = 2. After completion: pba = 0, msg_count = 1, rr_ptr = 3.
- Round-robin: irq_req = 8'h13 in one cycle, rr_ptr = 0 → issue order 0, 1, 4. Then irq_req = 8'h03 → order 0, 1 (pointer wrapped past 4 to 5, then scan wraps to 0).
- Masking: vector_mask = 8'h08, irq_req bit 3 pulsed → pba = 8'h08 and no fire for 20 cycles. Clear the mask → fire with index 3 within 2 cycles. Repeat using function_mask.
- Re-request during flight: pulse vector 5, then pulse vector 5 again in the same cycle req_complete is high → pba[5] stays 1 and a second message for index 5 is issued; msg_count = 2.
- Disable: pba = 8'hFF, msix_enable 1→0 → pba = 0 next cycle, no fire, irq_req ignored. A transaction already in ISSUE completes normally.
- Async reset mid-ISSUE: assert rst while req_fire = 1 → req_fire, pba, msg_count and busy are 0 immediately, without waiting for a clock edge. The next request after release is issued normally.
